iir_coeff_loader: RTL and testbench
===================================

// Module: iir_coeff_loader
// PURPOSE
// - Stream-to-register writer for the IIR notch-chain coefficient ports.
// - Accepts coefficient-programming frames on a valid/ready word stream.
// - Assembles 3 numerator and 2 denominator coefficients, then commits them to one notch stage.
// - Commit drives the shared num/den buses and pulses that stage's write enables.
// - Sits between the host config path and the IIR chain.
// PARAMETERS
// - COEFF_WIDTH      20  coefficient word width, signed, Q(COEFF_WIDTH-COEFF_FRAC).COEFF_FRAC
// - COEFF_FRAC       18  fractional bits; documentation only, no arithmetic performed
// - NUM_COEFF_DEPTH   3  numerator taps b0..b2 (localparam, from package)
// - DEN_COEFF_DEPTH   2  denominator taps a1..a2 (localparam, from package)
// PORTS
// - clk                  in   1              single clock
// - rst_n                in   1              reset, synchronous, active-low
// - s_valid              in   1              input word valid
// - s_ready              out  1              loader can accept a word
// - s_data               in   COEFF_WIDTH    header or coefficient word (signed)
// - abort                in   1              discard partial frame, return to IDLE
// - num_coeff_out        out  COEFF_WIDTH x3 shared numerator bus, index 0 = b0
// - den_coeff_out        out  COEFF_WIDTH x2 shared denominator bus, index 0 = a1
// - num_coeff_1_wr_en    out  1              commit pulse, 1 MHz notch
// - den_coeff_1_wr_en    out  1              commit pulse, 1 MHz notch
// - num_coeff_2_wr_en    out  1              commit pulse, 2 MHz notch
// - den_coeff_2_wr_en    out  1              commit pulse, 2 MHz notch
// - num_coeff_2_4_wr_en  out  1              commit pulse, 2.4 MHz notch
// - den_coeff_2_4_wr_en  out  1              commit pulse, 2.4 MHz notch
// - busy                 out  1              a frame is in progress (state != IDLE)
// - done                 out  1              1-cycle pulse with a successful commit
// - sel_err              out  1              sticky: last header carried an invalid stage select
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): state=IDLE, word_cnt=0, all coefficient registers 0.
//   All wr_en=0, done=0, busy=0, sel_err=0, s_ready=0 during reset.
// - Handshake: word accepted on a posedge with s_valid & s_ready.
//   s_data must stay stable while s_valid=1 and s_ready=0.
// - Frame = 6 words: header, then b0, b1, b2, a1, a2.
//   Header s_data[1:0] = stage select: 0 = 1 MHz, 1 = 2 MHz, 2 = 2.4 MHz, 3 = invalid.
//   Header bits above [1:0] are ignored.
// - States:
//   - IDLE: s_ready=1. Header accepted -> NUM, word_cnt=0, sel latched.
//     sel_err <= (sel==3); a valid select clears sel_err.
//   - NUM: s_ready=1. Each accepted word -> staging num reg[word_cnt].
//     word_cnt==2 on accept -> DEN, word_cnt=0.
//   - DEN: s_ready=1. Each accepted word -> staging den reg[word_cnt].
//     word_cnt==1 on accept -> COMMIT if sel!=3, else IDLE (frame drained, nothing written).
//   - COMMIT (exactly 1 cycle): s_ready=0.
//     Staging regs copy to num/den_coeff_out; the selected stage's num and den wr_en are 1.
//     done=1. Next state IDLE.
// - Latency: wr_en/done are asserted in the cycle immediately after the a2 handshake.
//   num/den_coeff_out carry the new values in that same cycle.
// - num/den_coeff_out only change in COMMIT and hold between commits (stable for the IIR write).
//   Staging regs are separate, so a partial frame never disturbs the output buses.
// - At most one stage's wr_en pair is high in any cycle.
//   The num and den enables of that stage are always asserted together.
// - Back-to-back frames: a header is accepted in the first IDLE cycle after COMMIT; there are no extra bubbles.
// - abort in IDLE/NUM/DEN: s_ready forced 0 that cycle; abort wins over a simultaneous s_valid.
//   Effects: next state IDLE, word_cnt=0, staging discarded, no wr_en, outputs unchanged, sel_err unchanged.
// - abort during COMMIT is ignored; the commit completes.
// - Reset mid-frame: no wr_en is produced and outputs return to reset values.
// - word_cnt is 2 bits, never exceeds 2, and never wraps.
// STRUCTURE
// - iir_pkg holds: state enum {IDLE, NUM, DEN, COMMIT}.
// - iir_pkg holds stage constants IIR_1_NOTCH=0, IIR_2_NOTCH=1, IIR_2_4_NOTCH=2, SEL_INVALID=3.
// - iir_pkg holds NUM_COEFF_DEPTH=3 and DEN_COEFF_DEPTH=2.
// - Single flat module; no sub-module. FSM, word counter, staging regs and output regs are all local.
// - The chain's *_in coefficient ports all connect to num/den_coeff_out; stage selection is by wr_en only.
// TESTING
// - Reset: hold rst_n=0 for 3 cycles -> all outputs 0; s_ready=1 the cycle after release.
// - Frame sel=2, words 0x10000, 0x2000, 0x10000, 0xF8000, 0x3C000 with s_valid held high.
//   Required: num/den_coeff_2_4_wr_en=1 for exactly 1 cycle, 1 cycle after the last handshake.
//   Required: outputs match the words; done=1; other enables stay 0.
// - Frame sel=0 with random s_valid gaps, then frame sel=1 back-to-back.
//   Required: _1 pair pulses, then the _2 pair; second header accepted the cycle after COMMIT.
// - Frame sel=3 -> sel_err=1 after the header; 5 words consumed; no wr_en, no done.
//   A following sel=1 frame clears sel_err and commits normally.
// - abort after b1 together with s_valid=1 -> that word is not accepted, busy=0 next cycle, no wr_en.
//   Next full frame commits only its own values.
// - rst_n=0 during the DEN state -> no wr_en pulse and coefficient outputs read 0.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR notch-chain coefficient loader.
package iir_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      NUM    = 2'd1,
      DEN    = 2'd2,
      COMMIT = 2'd3
   } state_t;

   // Header stage-select codes
   localparam logic [1:0] IIR_1_NOTCH   = 2'd0;
   localparam logic [1:0] IIR_2_NOTCH   = 2'd1;
   localparam logic [1:0] IIR_2_4_NOTCH = 2'd2;
   localparam logic [1:0] SEL_INVALID   = 2'd3;

   localparam int unsigned NUM_COEFF_DEPTH = 3;
   localparam int unsigned DEN_COEFF_DEPTH = 2;

endpackage : iir_pkg

// File: rtl/iir_coeff_loader.sv
// Assembles b0..b2 / a1..a2 frames from a valid/ready word stream and commits
// them to one notch stage through the shared coefficient buses.
module iir_coeff_loader
   import iir_pkg::*;
#(
   parameter int unsigned COEFF_WIDTH = 20,
   parameter int unsigned COEFF_FRAC  = 18
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          s_valid,
   output logic                                          s_ready,
   input  logic [COEFF_WIDTH-1:0]                        s_data,
   input  logic                                          abort,
   output logic [NUM_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]   num_coeff_out,
   output logic [DEN_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]   den_coeff_out,
   output logic                                          num_coeff_1_wr_en,
   output logic                                          den_coeff_1_wr_en,
   output logic                                          num_coeff_2_wr_en,
   output logic                                          den_coeff_2_wr_en,
   output logic                                          num_coeff_2_4_wr_en,
   output logic                                          den_coeff_2_4_wr_en,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          sel_err
);

   if (COEFF_FRAC >= COEFF_WIDTH) begin : g_bad_frac
      $error("COEFF_FRAC must be smaller than COEFF_WIDTH");
   end

   state_t                                        state;
   logic [1:0]                                    word_cnt;
   logic [1:0]                                    sel;
   logic                                          ready_q;
   logic [NUM_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]   num_stg;
   logic [DEN_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]   den_stg;
   logic                                          accept;

   // ready_q is low only in COMMIT and reset; abort masks the handshake that cycle
   assign s_ready = ready_q & ~abort & rst_n;
   assign accept  = s_valid & s_ready;
   assign busy    = (state != IDLE);

   // Frame FSM, word counter, staging and committed output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= IDLE;
         word_cnt            <= '0;
         sel                 <= IIR_1_NOTCH;
         sel_err             <= 1'b0;
         ready_q             <= 1'b0;
         num_stg             <= '0;
         den_stg             <= '0;
         num_coeff_out       <= '0;
         den_coeff_out       <= '0;
         num_coeff_1_wr_en   <= 1'b0;
         den_coeff_1_wr_en   <= 1'b0;
         num_coeff_2_wr_en   <= 1'b0;
         den_coeff_2_wr_en   <= 1'b0;
         num_coeff_2_4_wr_en <= 1'b0;
         den_coeff_2_4_wr_en <= 1'b0;
         done                <= 1'b0;
      end else begin
         ready_q             <= 1'b1;
         done                <= 1'b0;
         num_coeff_1_wr_en   <= 1'b0;
         den_coeff_1_wr_en   <= 1'b0;
         num_coeff_2_wr_en   <= 1'b0;
         den_coeff_2_wr_en   <= 1'b0;
         num_coeff_2_4_wr_en <= 1'b0;
         den_coeff_2_4_wr_en <= 1'b0;

         case (state)
            IDLE: begin
               if (abort) begin
                  word_cnt <= '0;
               end else if (accept) begin
                  sel      <= s_data[1:0];
                  sel_err  <= (s_data[1:0] == SEL_INVALID);
                  word_cnt <= '0;
                  state    <= NUM;
               end
            end

            NUM: begin
               if (abort) begin
                  word_cnt <= '0;
                  state    <= IDLE;
               end else if (accept) begin
                  num_stg[word_cnt] <= s_data;
                  if (word_cnt == 2'(NUM_COEFF_DEPTH - 1)) begin
                     word_cnt <= '0;
                     state    <= DEN;
                  end else begin
                     word_cnt <= word_cnt + 2'd1;
                  end
               end
            end

            DEN: begin
               if (abort) begin
                  word_cnt <= '0;
                  state    <= IDLE;
               end else if (accept) begin
                  den_stg[word_cnt[0]] <= s_data;
                  if (word_cnt == 2'(DEN_COEFF_DEPTH - 1)) begin
                     word_cnt <= '0;
                     // An invalid select drains the frame without writing anything
                     if (sel != SEL_INVALID) begin
                        state   <= COMMIT;
                        ready_q <= 1'b0;
                     end else begin
                        state   <= IDLE;
                     end
                  end else begin
                     word_cnt <= word_cnt + 2'd1;
                  end
               end
            end

            COMMIT: begin
               num_coeff_out       <= num_stg;
               den_coeff_out       <= den_stg;
               done                <= 1'b1;
               num_coeff_1_wr_en   <= (sel == IIR_1_NOTCH);
               den_coeff_1_wr_en   <= (sel == IIR_1_NOTCH);
               num_coeff_2_wr_en   <= (sel == IIR_2_NOTCH);
               den_coeff_2_wr_en   <= (sel == IIR_2_NOTCH);
               num_coeff_2_4_wr_en <= (sel == IIR_2_4_NOTCH);
               den_coeff_2_4_wr_en <= (sel == IIR_2_4_NOTCH);
               state               <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule : iir_coeff_loader

// File: tb/tb_iir_coeff_loader.sv
// Directed self-checking bench for iir_coeff_loader.
module tb_iir_coeff_loader;

   localparam int unsigned CW = 20;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                s_valid = 1'b0;
   logic                abort = 1'b0;
   logic [CW-1:0]       s_data = '0;
   logic                s_ready;
   logic [2:0][CW-1:0]  num;
   logic [1:0][CW-1:0]  den;
   logic                n1, d1, n2, d2, n24, d24;
   logic                busy, done, sel_err;
   logic [5:0]          en_vec;

   iir_coeff_loader dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .s_data              (s_data),
      .abort               (abort),
      .num_coeff_out       (num),
      .den_coeff_out       (den),
      .num_coeff_1_wr_en   (n1),
      .den_coeff_1_wr_en   (d1),
      .num_coeff_2_wr_en   (n2),
      .den_coeff_2_wr_en   (d2),
      .num_coeff_2_4_wr_en (n24),
      .den_coeff_2_4_wr_en (d24),
      .busy                (busy),
      .done                (done),
      .sel_err             (sel_err)
   );

   assign en_vec = {n1, d1, n2, d2, n24, d24};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Commit monitor: per-stage pulse counts, cycle and bus values at the pulse
   int          en_cnt [3] = '{0, 0, 0};
   int          en_cyc [3] = '{0, 0, 0};
   logic [59:0] en_num [3];
   logic [39:0] en_den [3];
   int          done_cnt = 0;
   int          bad_cnt = 0;

   always @(negedge clk) begin
      logic [2:0] nv;
      logic [2:0] dv;
      nv = {n24, n2, n1};
      dv = {d24, d2, d1};
      if (nv != dv || $countones(nv) > 1 || done != (nv != 3'b000))
         bad_cnt++;
      for (int s = 0; s < 3; s++) begin
         if (nv[s]) begin
            en_cnt[s]++;
            en_cyc[s] = cyc;
            en_num[s] = num;
            en_den[s] = den;
         end
      end
      if (done) done_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one word, wait (bounded) for its handshake; hs = cycle of acceptance
   task automatic send_word(input logic [CW-1:0] d, input int gap, output int hs);
      int   n;
      logic ok;
      repeat (gap) begin
         s_valid = 1'b0;
         tick(1);
      end
      s_valid = 1'b1;
      s_data  = d;
      n = 0;
      while (1) begin
         ok = s_ready;
         tick(1);
         if (ok === 1'b1) break;
         n++;
         if (n >= 16) begin
            check("hs_timeout", 64'(s_ready), 64'd1);
            break;
         end
      end
      hs = cyc;
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [CW-1:0] hdr, input logic [CW-1:0] b0,
                             input logic [CW-1:0] b1, input logic [CW-1:0] b2,
                             input logic [CW-1:0] a1, input logic [CW-1:0] a2,
                             input int max_gap, output int first_hs, output int last_hs);
      logic [CW-1:0] w [6];
      int hs;
      w = '{hdr, b0, b1, b2, a1, a2};
      for (int i = 0; i < 6; i++) begin
         send_word(w[i], int'($urandom_range(32'(max_gap), 0)), hs);
         if (i == 0) first_hs = hs;
      end
      last_hs = hs;
   endtask

   initial begin
      int h0, l0, h1, l1, h2, l2, hs;

      // Reset held for 3 cycles
      tick(3);
      check("rst_ready",   64'(s_ready), 64'd0);
      check("rst_busy",    64'(busy),    64'd0);
      check("rst_done",    64'(done),    64'd0);
      check("rst_sel_err", 64'(sel_err), 64'd0);
      check("rst_wr_en",   64'(en_vec),  64'd0);
      check("rst_num",     64'(num),     64'd0);
      check("rst_den",     64'(den),     64'd0);
      rst_n = 1'b1;
      tick(1);
      check("ready_after_rst", 64'(s_ready), 64'd1);

      // sel=2 frame with s_valid held high; header upper bits are junk
      send_frame(20'hABCD2, 20'h10000, 20'h02000, 20'h10000, 20'hF8000, 20'h3C000, 0, h0, l0);
      check("s24_ready_commit", 64'(s_ready), 64'd0);
      tick(1);
      check("s24_wr_en",  64'(en_vec), 64'b000011);
      check("s24_done",   64'(done),   64'd1);
      check("s24_num",    64'(num),    64'({20'h10000, 20'h02000, 20'h10000}));
      check("s24_den",    64'(den),    64'({20'h3C000, 20'hF8000}));
      tick(1);
      check("s24_wr_en_off", 64'(en_vec), 64'd0);
      check("s24_done_off",  64'(done),   64'd0);
      check("s24_cyc", 64'(en_cyc[2]), 64'(l0 + 1));
      tick(2);
      check("s24_cnt", 64'(en_cnt[2]), 64'd1);

      // sel=0 with random gaps, then sel=1 back-to-back
      send_frame(20'h00000, 20'h01111, 20'h02222, 20'h03333, 20'hFC444, 20'h05555, 3, h1, l1);
      send_frame(20'h00001, 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'hF1234, 20'h04321, 0, h2, l2);
      check("b2b_hdr_cyc", 64'(h2), 64'(l1 + 2));
      tick(3);
      check("s1_cnt", 64'(en_cnt[0]), 64'd1);
      check("s1_cyc", 64'(en_cyc[0]), 64'(l1 + 1));
      check("s1_num", 64'(en_num[0]), 64'({20'h03333, 20'h02222, 20'h01111}));
      check("s1_den", 64'(en_den[0]), 64'({20'h05555, 20'hFC444}));
      check("s2_cnt", 64'(en_cnt[1]), 64'd1);
      check("s2_cyc", 64'(en_cyc[1]), 64'(l2 + 1));
      check("s2_num", 64'(en_num[1]), 64'({20'h0CCCC, 20'h0BBBB, 20'h0AAAA}));
      check("s2_den", 64'(en_den[1]), 64'({20'h04321, 20'hF1234}));
      check("s24_cnt_hold", 64'(en_cnt[2]), 64'd1);

      // Invalid select: frame drained, nothing written
      send_word(20'hFFFF3, 0, hs);
      check("inv_sel_err", 64'(sel_err), 64'd1);
      send_word(20'h11111, 0, hs);
      send_word(20'h22222, 1, hs);
      send_word(20'h33333, 0, hs);
      send_word(20'h44444, 2, hs);
      send_word(20'h55555, 0, hs);
      tick(3);
      check("inv_busy", 64'(busy),     64'd0);
      check("inv_done", 64'(done_cnt), 64'd3);
      check("inv_cnt",  64'(en_cnt[0] + en_cnt[1] + en_cnt[2]), 64'd3);
      check("inv_num_hold", 64'(num), 64'({20'h0CCCC, 20'h0BBBB, 20'hAAAA}));

      // Valid sel=1 clears sel_err and commits
      send_word(20'h00005, 0, hs);
      check("sel_err_clr", 64'(sel_err), 64'd0);
      send_word(20'h00021, 0, hs);
      send_word(20'h00042, 0, hs);
      send_word(20'h00063, 0, hs);
      send_word(20'h00084, 0, hs);
      send_word(20'h000A5, 0, l2);
      tick(3);
      check("s2b_cnt", 64'(en_cnt[1]), 64'd2);
      check("s2b_cyc", 64'(en_cyc[1]), 64'(l2 + 1));
      check("s2b_num", 64'(en_num[1]), 64'({20'h00063, 20'h00042, 20'h00021}));
      check("s2b_den", 64'(en_den[1]), 64'({20'h000A5, 20'h00084}));

      // Abort after b1 together with a valid word
      send_word(20'h00000, 0, hs);
      send_word(20'h0DEAD, 0, hs);
      send_word(20'h0BEEF, 0, hs);
      s_valid = 1'b1;
      s_data  = 20'h77777;
      abort   = 1'b1;
      #1;
      check("abort_ready", 64'(s_ready), 64'd0);
      tick(1);
      abort   = 1'b0;
      s_valid = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      tick(3);
      check("abort_cnt",     64'(en_cnt[0]), 64'd1);
      check("abort_done",    64'(done_cnt),  64'd4);
      check("abort_num",     64'(num),       64'({20'h00063, 20'h00042, 20'h00021}));
      check("abort_sel_err", 64'(sel_err),   64'd0);

      // Next full frame commits only its own values
      send_frame(20'h00000, 20'h00101, 20'h00202, 20'h00303, 20'h00404, 20'h00505, 1, h1, l1);
      tick(3);
      check("post_abort_cnt", 64'(en_cnt[0]), 64'd2);
      check("post_abort_cyc", 64'(en_cyc[0]), 64'(l1 + 1));
      check("post_abort_num", 64'(en_num[0]), 64'({20'h00303, 20'h00202, 20'h00101}));
      check("post_abort_den", 64'(en_den[0]), 64'({20'h00505, 20'h00404}));

      // Reset while in DEN
      send_word(20'h00002, 0, hs);
      send_word(20'h12345, 0, hs);
      send_word(20'h23456, 0, hs);
      send_word(20'h34567, 0, hs);
      send_word(20'h45678, 0, hs);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_wr_en", 64'(en_vec),  64'd0);
      check("mid_rst_num",   64'(num),     64'd0);
      check("mid_rst_den",   64'(den),     64'd0);
      check("mid_rst_busy",  64'(busy),    64'd0);
      check("mid_rst_ready", 64'(s_ready), 64'd0);
      tick(1);
      rst_n = 1'b1;
      tick(3);
      check("mid_rst_cnt",  64'(en_cnt[2]), 64'd1);
      check("total_done",   64'(done_cnt),  64'd5);
      check("pair_onehot",  64'(bad_cnt),   64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_iir_coeff_loader
